// File: rtl/sort_calc_seq_ctrl.sv
// Serial 6x4-bit load, bubble sort on one compare-exchange unit, rule mapping, one shared 4x4 multiply.
// Result 19 edges after the 6th accept; in_ready low while busy, so in_valid is simply not taken then.
module sort_calc_seq_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_data,
  input  logic [2:0]        in_rule,
  output logic              busy,
  output logic              out_valid,
  output logic signed [9:0] out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_MAP,
    S_MUL1,
    S_MUL2,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_cnt;
  logic [2:0]        r_rule;
  logic [2:0]        r_pass;
  logic [2:0]        r_j;
  logic [5:0][3:0]   r_op;
  logic [5:0][3:0]   r_map;
  logic [7:0]        r_p1;
  logic [7:0]        r_p2;
  logic signed [9:0] r_out;
  logic              r_out_vld;

  logic              w_xfer;
  logic              w_j_end;
  logic [2:0]        w_j1;
  logic [3:0]        w_x;
  logic [3:0]        w_y;
  logic              w_swap;
  logic [5:0][3:0]   w_map;
  logic [3:0]        w_mx;
  logic [3:0]        w_my;
  logic [7:0]        w_prod;
  logic signed [9:0] w_p1s;
  logic signed [9:0] w_p2s;
  logic signed [9:0] w_e4;
  logic signed [9:0] w_half;
  logic signed [9:0] w_res;

  assign in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy      = ~in_ready;
  assign out_valid = r_out_vld;
  assign out       = r_out;
  assign w_xfer    = in_valid && in_ready;

  // Compare-exchange unit: pass p walks j over 0..4-p, 15 steps in total.
  assign w_j1    = r_j + 3'd1;
  assign w_j_end = (r_j == (3'd4 - r_pass));
  assign w_x     = r_op[r_j];
  assign w_y     = r_op[w_j1];
  assign w_swap  = (w_x > w_y);

  // r_map[0..5] hold a..f.
  always_comb begin
    w_map = r_op;
    case (r_rule[2:1])
      2'b00:   w_map = r_op;
      2'b01:   w_map = {r_op[4], r_op[2], r_op[0], r_op[5], r_op[3], r_op[1]};
      2'b10:   w_map = {r_op[1], r_op[3], r_op[5], r_op[4], r_op[2], r_op[0]};
      default: w_map = {r_op[4], r_op[2], r_op[0], r_op[1], r_op[3], r_op[5]};
    endcase
  end

  // Shared multiplier: the operand pair slides one position for the second product.
  always_comb begin
    w_mx = r_rule[0] ? r_map[1] : r_map[0];
    w_my = r_rule[0] ? r_map[2] : r_map[1];
    if (r_state == S_MUL2) begin
      w_mx = r_rule[0] ? r_map[2] : r_map[1];
      w_my = r_rule[0] ? r_map[3] : r_map[2];
    end
  end

  assign w_prod = {4'b0000, w_mx} * {4'b0000, w_my};

  assign w_p1s  = $signed({2'b00, r_p1});
  assign w_p2s  = $signed({2'b00, r_p2});
  assign w_e4   = $signed({4'b0000, r_map[4], 2'b00});
  assign w_half = $signed({7'b0000000, r_map[5][3:1]});
  assign w_res  = r_rule[0] ? (w_p1s - w_p2s + w_half) : (w_p1s + w_p2s - w_e4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_LOAD;
      S_LOAD:  if (w_xfer && (r_cnt == 3'd5)) w_next = S_SORT;
      S_SORT:  if (w_j_end && (r_pass == 3'd4)) w_next = S_MAP;
      S_MAP:   w_next = S_MUL1;
      S_MUL1:  w_next = S_MUL2;
      S_MUL2:  w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= 3'd0;
      r_rule    <= 3'd0;
      r_pass    <= 3'd0;
      r_j       <= 3'd0;
      r_op      <= '0;
      r_map     <= '0;
      r_p1      <= 8'd0;
      r_p2      <= 8'd0;
      r_out     <= 10'sd0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_op[0] <= in_data;
            r_rule  <= in_rule;
            r_cnt   <= 3'd1;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_op[r_cnt] <= in_data;
            r_cnt       <= r_cnt + 3'd1;
            if (r_cnt == 3'd5) begin
              r_pass <= 3'd0;
              r_j    <= 3'd0;
            end
          end
        end
        S_SORT: begin
          if (w_swap) begin
            r_op[r_j]  <= w_y;
            r_op[w_j1] <= w_x;
          end
          if (w_j_end) begin
            r_j    <= 3'd0;
            r_pass <= r_pass + 3'd1;
          end else begin
            r_j <= w_j1;
          end
        end
        S_MAP:  r_map <= w_map;
        S_MUL1: r_p1  <= w_prod;
        S_MUL2: r_p2  <= w_prod;
        S_FIN: begin
          r_out     <= w_res;
          r_out_vld <= 1'b1;
          r_cnt     <= 3'd0;
        end
        default: r_cnt <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_calc_seq_ctrl.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them on out_valid.
module tb_sort_calc_seq_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_data;
  logic [2:0]        in_rule;
  logic              busy;
  logic              out_valid;
  logic signed [9:0] out;

  typedef struct {
    int          exp;
    logic [23:0] srt;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_xfer = 0;
  int   exp_xfer = 0;
  int   last_out = 0;
  int   last_acc6 = 0;

  sort_calc_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rule   (in_rule),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) n_xfer++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    logic [3:0] v0, v1, v2, v3, v4, v5;
    v0 = a0[3:0]; v1 = a1[3:0]; v2 = a2[3:0];
    v3 = a3[3:0]; v4 = a4[3:0]; v5 = a5[3:0];
    return {v5, v4, v3, v2, v1, v0};
  endfunction

  // Reference: sort ascending, pick a..f through the rule's index table, evaluate with integers.
  function automatic int model(input logic [23:0] ops, input logic [2:0] rule,
                               output logic [23:0] srt);
    int s[$];
    int mt[4][6];
    int r, a, b, c, d, e, f, v;
    mt = '{'{0, 1, 2, 3, 4, 5}, '{1, 3, 5, 0, 2, 4},
           '{0, 2, 4, 5, 3, 1}, '{5, 3, 1, 0, 2, 4}};
    for (int i = 0; i < 6; i++) s.push_back(int'(ops[i*4 +: 4]));
    s.sort();
    srt = '0;
    for (int i = 0; i < 6; i++) begin
      v = s[i];
      srt[i*4 +: 4] = v[3:0];
    end
    r = int'(rule[2:1]);
    a = s[mt[r][0]]; b = s[mt[r][1]]; c = s[mt[r][2]];
    d = s[mt[r][3]]; e = s[mt[r][4]]; f = s[mt[r][5]];
    if (rule[0]) return b*c - c*d + f/2;
    return a*b + b*c - 4*e;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; holds in_valid until accepted, returns at the negedge after the accept.
  task automatic send(input logic [3:0] d, input logic [2:0] rl);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_rule  = rl;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic txn(input logic [23:0] ops, input logic [2:0] rule, input int gap2, input bit b2b);
    int   first_acc = 0;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 2 && gap2 > 0) idle(gap2);
      send(ops[i*4 +: 4], (i == 0) ? rule : 3'($urandom));
      if (i == 0) first_acc = cyc;
    end
    exp_xfer += 6;
    if (b2b) chk("b2b_first_accept", first_acc - last_acc6, 20);
    last_acc6 = cyc;
    e.exp = model(ops, rule, e.srt);
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_vs_busy", int'(in_ready), int'(!busy));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", int'(out), e.exp);
          chk("sorted_regs", int'(dut.r_op), int'(e.srt));
          chk("latency", cyc - e.acc, 19);
          last_out = e.exp;
        end
      end else begin
        chk("out_hold", int'(out), last_out);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] pi;
    int g0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    in_rule  = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_out", int'(out), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    pi = pk(3, 1, 4, 1, 5, 9);
    txn(pi, 3'b000, 0, 1'b0);
    txn(pi, 3'b001, 0, 1'b1);
    txn(pi, 3'b010, 0, 1'b1);
    txn(pi, 3'b111, 0, 1'b1);
    txn(pk(15, 15, 15, 15, 15, 15), 3'b000, 0, 1'b1);
    txn(pk(15, 15, 15, 15, 15, 15), 3'b101, 0, 1'b1);
    txn(pk(0, 0, 0, 0, 0, 0), 3'b001, 0, 1'b1);
    txn(pk(9, 8, 7, 6, 5, 4), 3'b011, 0, 1'b1);
    txn(pi, 3'b000, 3, 1'b1);
    txn(pk(1, 9, 3, 5, 1, 4), 3'b000, 0, 1'b1);
    drain();
    chk("idle_in_ready", int'(in_ready), 1);

    txn(pk(2, 7, 1, 8, 2, 8), 3'b000, 0, 1'b0);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midsort_rst_out", int'(out), 0);
    chk("midsort_rst_out_valid", int'(out_valid), 0);
    chk("midsort_rst_in_ready", int'(in_ready), 1);
    chk("midsort_rst_busy", int'(busy), 0);
    chk("midsort_rst_regs", int'(dut.r_op), 0);
    q.delete();
    last_out = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    txn(pk(5, 3, 12, 0, 7, 7), 3'b110, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      logic [23:0] ops;
      int hi;
      hi = ($urandom_range(0, 2) == 0) ? 3 : 15;
      for (int i = 0; i < 6; i++) ops[i*4 +: 4] = 4'($urandom_range(0, hi));
      g0 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      if (g0 > 0) idle(g0);
      txn(ops, 3'($urandom), $urandom_range(0, 2), g0 == 0);
    end
    drain();
    chk("transfer_count", n_xfer, exp_xfer);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
